// File: rtl/pixie_dma_scheduler.sv
// pixie_dma_scheduler: CDP1861-style video timing and DMA sequencer.
// Counts 1802 machine cycles (TPA ticks) into lines and frames. It raises
// INT and EFx around the display window and issues DMA-out requests. It also
// turns each acknowledged DMA cycle into a single byte strobe for the shifter.
module pixie_dma_scheduler #(
   parameter int CYCLES_PER_LINE = 14,
   parameter int LINES_PER_FRAME = 262,
   parameter int FIRST_DMA_LINE  = 80,
   parameter int DMA_LINES       = 128,
   parameter int DMA_START_CYCLE = 2,
   parameter int DMA_BYTES       = 8,
   parameter int INT_LEAD        = 2,
   parameter int EF_LEAD         = 4
) (
   input  logic       clock,
   input  logic       Reset_,
   input  logic       TPA,
   input  logic       TPB,
   input  logic [1:0] SC,
   input  logic       Disp_On,
   input  logic       Disp_Off,
   output logic       DMAO,
   output logic       INT,
   output logic       EFx,
   output logic       byte_strobe,
   output logic [8:0] line_count,
   output logic [3:0] cycle_count,
   output logic       Locked,
   output logic       overrun
);

   localparam logic [3:0] CYC_LAST  = 4'(CYCLES_PER_LINE - 1);
   localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
   localparam logic [3:0] START_CYC = 4'(DMA_START_CYCLE);
   localparam logic [3:0] BYTES     = 4'(DMA_BYTES);
   localparam logic [8:0] DMA_LO    = 9'(FIRST_DMA_LINE);
   localparam logic [8:0] DMA_HI    = 9'(FIRST_DMA_LINE + DMA_LINES - 1);
   localparam logic [8:0] INT_LO    = 9'(FIRST_DMA_LINE - INT_LEAD);
   localparam logic [8:0] INT_HI    = 9'(FIRST_DMA_LINE - 1);
   localparam logic [8:0] EFA_LO    = 9'(FIRST_DMA_LINE - EF_LEAD);
   localparam logic [8:0] EFA_HI    = 9'(FIRST_DMA_LINE - 1);
   localparam logic [8:0] EFB_LO    = 9'(FIRST_DMA_LINE + DMA_LINES - EF_LEAD);
   localparam logic [8:0] EFB_HI    = 9'(FIRST_DMA_LINE + DMA_LINES - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} dma_state_t;

   dma_state_t state;
   logic [3:0] ack_cnt;
   logic [3:0] ack_inc;
   logic [3:0] ack_total;
   logic [3:0] cycle_nxt;
   logic [8:0] line_nxt;
   logic       disp_en;
   logic       int_acked;
   logic       locked_nxt;
   logic       acked_nxt;
   logic       cycle_wrap;
   logic       frame_wrap;
   logic       dma_ack;
   logic       int_ack;
   logic       start_hit;
   logic       in_window;

   function automatic logic in_range(input logic [8:0] v, input logic [8:0] lo,
                                     input logic [8:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   assign cycle_wrap = TPA && (cycle_count == CYC_LAST);
   assign frame_wrap = cycle_wrap && (line_count == LINE_LAST);
   assign dma_ack    = TPB && (SC == 2'b10);
   assign int_ack    = TPB && (SC == 2'b11);
   assign start_hit  = TPA && (cycle_nxt == START_CYC);
   assign in_window  = in_range(line_count, DMA_LO, DMA_HI);
   assign ack_inc    = ack_cnt + 4'd1;
   assign ack_total  = dma_ack ? ack_inc : ack_cnt;

   // Next-state values so INT/EFx/Locked line up with the counters they follow
   always_comb begin
      cycle_nxt = cycle_count;
      line_nxt  = line_count;
      if (TPA) begin
         if (cycle_count == CYC_LAST) begin
            cycle_nxt = '0;
            line_nxt  = (line_count == LINE_LAST) ? '0 : line_count + 9'd1;
         end else begin
            cycle_nxt = cycle_count + 4'd1;
         end
      end
      locked_nxt = Locked;
      if (Disp_Off) begin
         locked_nxt = 1'b0;
      end else if (frame_wrap) begin
         locked_nxt = disp_en;
      end
      acked_nxt = int_acked;
      if (frame_wrap) begin
         acked_nxt = 1'b0;
      end
      if (int_ack && INT) begin
         acked_nxt = 1'b1;
      end
   end

   // Timebase, display-enable latches and the registered INT/EFx flags
   always_ff @(posedge clock or negedge Reset_) begin
      if (!Reset_) begin
         cycle_count <= '0;
         line_count  <= '0;
         disp_en     <= 1'b0;
         Locked      <= 1'b0;
         int_acked   <= 1'b0;
         INT         <= 1'b0;
         EFx         <= 1'b0;
      end else begin
         cycle_count <= cycle_nxt;
         line_count  <= line_nxt;
         if (Disp_Off) begin
            disp_en <= 1'b0;
         end else if (Disp_On) begin
            disp_en <= 1'b1;
         end
         Locked    <= locked_nxt;
         int_acked <= acked_nxt;
         INT       <= locked_nxt && in_range(line_nxt, INT_LO, INT_HI) && !acked_nxt;
         EFx       <= in_range(line_nxt, EFA_LO, EFA_HI) || in_range(line_nxt, EFB_LO, EFB_HI);
      end
   end

   // DMA request sequencer: one request per window line, counts acks into strobes
   always_ff @(posedge clock or negedge Reset_) begin
      if (!Reset_) begin
         state       <= IDLE;
         DMAO        <= 1'b0;
         ack_cnt     <= '0;
         byte_strobe <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         byte_strobe <= 1'b0;
         if (Disp_On) begin
            overrun <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!Disp_Off && start_hit && Locked && in_window) begin
                  state   <= REQ;
                  DMAO    <= 1'b1;
                  ack_cnt <= '0;
               end
            end
            REQ: begin
               if (Disp_Off) begin
                  state <= IDLE;
                  DMAO  <= 1'b0;
               end else begin
                  if (dma_ack) begin
                     byte_strobe <= 1'b1;
                     ack_cnt     <= ack_inc;
                  end
                  if (cycle_wrap) begin
                     // line ended before the shifter got its full row
                     state <= IDLE;
                     DMAO  <= 1'b0;
                     if (ack_total < BYTES) begin
                        overrun <= 1'b1;
                     end
                  end else if (dma_ack && (ack_inc == BYTES)) begin
                     state <= DONE;
                     DMAO  <= 1'b0;
                  end
               end
            end
            DONE: begin
               if (Disp_Off || cycle_wrap) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               DMAO  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixie_dma_scheduler.sv
// Testbench for pixie_dma_scheduler: randomized CPU bus activity against a
// frame-level reference model; predictions are queued and a monitor compares.
module tb_pixie_dma_scheduler;

   localparam int CPL   = 14;
   localparam int LPF   = 262;
   localparam int FRAME = CPL * LPF;

   logic       clock = 1'b0;
   logic       Reset_ = 1'b0;
   logic       TPA = 1'b0;
   logic       TPB = 1'b0;
   logic [1:0] SC = 2'b00;
   logic       Disp_On = 1'b0;
   logic       Disp_Off = 1'b0;
   logic       DMAO;
   logic       INT;
   logic       EFx;
   logic       byte_strobe;
   logic [8:0] line_count;
   logic [3:0] cycle_count;
   logic       Locked;
   logic       overrun;

   int total = 0;
   int bad = 0;

   // reference model state: machine cycles since frame start and frame-level flags
   int m_n = 0;
   int m_acks = 0;
   bit m_en, m_locked, m_acked, m_int, m_ef, m_req, m_ovr, m_strobe;
   bit int_ack_en = 1'b0;

   logic [18:0] exp_q[$];
   logic [12:0] strobe_q[$];
   logic [18:0] mon_e, mon_a;
   logic [12:0] mon_t;

   pixie_dma_scheduler dut (
      .clock(clock), .Reset_(Reset_), .TPA(TPA), .TPB(TPB), .SC(SC),
      .Disp_On(Disp_On), .Disp_Off(Disp_Off), .DMAO(DMAO), .INT(INT), .EFx(EFx),
      .byte_strobe(byte_strobe), .line_count(line_count), .cycle_count(cycle_count),
      .Locked(Locked), .overrun(overrun)
   );

   always #5 clock = ~clock;

   function automatic int m_line();
      return m_n / CPL;
   endfunction

   function automatic int m_cyc();
      return m_n % CPL;
   endfunction

   function automatic bit in_r(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

   task automatic model_reset();
      m_n = 0; m_acks = 0;
      m_en = 0; m_locked = 0; m_acked = 0; m_int = 0; m_ef = 0;
      m_req = 0; m_ovr = 0; m_strobe = 0;
      exp_q.delete();
      strobe_q.delete();
   endtask

   // apply the display rules to one clock's worth of bus inputs
   task automatic model_update(input bit tpa, input bit tpb, input bit [1:0] sc,
                               input bit on, input bit off);
      int ln, cyc, nln, ncyc;
      bit wrap, fwrap, dack, iack, old_int, old_locked, old_en;
      ln = m_line(); cyc = m_cyc();
      wrap = tpa && (cyc == CPL - 1);
      fwrap = wrap && (ln == LPF - 1);
      dack = tpb && (sc == 2'b10);
      iack = tpb && (sc == 2'b11);
      old_int = m_int; old_locked = m_locked; old_en = m_en;
      if (tpa) m_n = (m_n + 1) % FRAME;
      nln = m_line(); ncyc = m_cyc();
      m_strobe = 0;
      if (on) m_ovr = 0;
      if (off) begin
         m_req = 0;
      end else if (m_req) begin
         if (dack) begin
            m_strobe = 1;
            m_acks++;
            strobe_q.push_back({9'(nln), 4'(ncyc)});
         end
         if (wrap) begin
            if (m_acks < 8) m_ovr = 1;
            m_req = 0;
         end else if (m_acks >= 8) begin
            m_req = 0;
         end
      end else if (tpa && ncyc == 2 && old_locked && in_r(ln, 80, 207)) begin
         m_req = 1;
         m_acks = 0;
      end
      if (off) m_en = 0;
      else if (on) m_en = 1;
      if (off) m_locked = 0;
      else if (fwrap) m_locked = old_en;
      if (fwrap) m_acked = 0;
      if (iack && old_int) m_acked = 1;
      m_int = m_locked && in_r(nln, 78, 79) && !m_acked;
      m_ef = in_r(nln, 76, 79) || in_r(nln, 204, 207);
      exp_q.push_back({9'(nln), 4'(ncyc), m_req, m_int, m_ef, m_locked, m_ovr, m_strobe});
   endtask

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic step(input bit tpa, input bit tpb, input bit [1:0] sc,
                       input bit on, input bit off);
      TPA = tpa; TPB = tpb; SC = sc; Disp_On = on; Disp_Off = off;
      @(posedge clock);
      #1;
      model_update(tpa, tpb, sc, on, off);
      TPA = 0; TPB = 0; SC = 2'b00; Disp_On = 0; Disp_Off = 0;
   endtask

   // one machine cycle: TPA clock, optional idle clock, TPB clock
   task automatic mc(input bit on, input bit off, input int limit, input bit iack);
      bit [1:0] sc;
      step(1, 0, 2'b00, on, off);
      if ($urandom_range(3) == 0) step(0, 0, 2'($urandom_range(3)), 0, 0);
      if (iack) sc = 2'b11;
      else if (m_req && m_acks < limit && !(m_cyc() <= 5 && $urandom_range(3) == 0)) sc = 2'b10;
      else if (m_int && int_ack_en && $urandom_range(3) == 0) sc = 2'b11;
      else if (!m_req && !m_int) sc = 2'($urandom_range(3));
      else sc = 2'b00;
      step(0, 1, sc, 0, 0);
   endtask

   task automatic run_mcs(input int n);
      for (int i = 0; i < n; i++) mc(0, 0, 8, 0);
   endtask

   task automatic run_until(input int ln, input int cyc);
      int guard;
      guard = 0;
      while (!(m_line() == ln && m_cyc() == cyc) && guard <= FRAME) begin
         mc(0, 0, 8, 0);
         guard++;
      end
      chk("run_until_reached", guard <= FRAME, 1);
   endtask

   // monitor: every prediction is compared the half-cycle after it is made
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = {line_count, cycle_count, DMAO, INT, EFx, Locked, overrun, byte_strobe};
         total++;
         if (mon_a !== mon_e) begin
            bad++;
            $display("FAIL cycle_state t=%0t actual line=%0d cyc=%0d flags(dmao,int,ef,lock,ovr,stb)=%b required line=%0d cyc=%0d flags=%b",
                     $time, mon_a[18:10], mon_a[9:6], mon_a[5:0], mon_e[18:10], mon_e[9:6], mon_e[5:0]);
         end
      end
      if (byte_strobe === 1'b1) begin
         total++;
         if (strobe_q.size() == 0) begin
            bad++;
            $display("FAIL strobe_unexpected actual=1 required=0 line=%0d cyc=%0d", line_count, cycle_count);
         end else begin
            mon_t = strobe_q.pop_front();
            if ({line_count, cycle_count} !== mon_t) begin
               bad++;
               $display("FAIL strobe_position actual=%0d/%0d required=%0d/%0d",
                        line_count, cycle_count, mon_t[12:4], mon_t[3:0]);
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk("reset_state", int'({line_count, cycle_count, DMAO, INT, EFx, Locked, overrun, byte_strobe}), 0);
      Reset_ = 1'b1;

      // frame 0: display disabled, bus noise only
      run_mcs(FRAME);
      chk("frame_wrap_line", int'(line_count), 0);
      chk("frame_wrap_cycle", int'(cycle_count), 0);
      chk("frame0_locked", int'(Locked), 0);

      // frame 1: enable mid-stream; Locked waits for the frame wrap
      mc(1, 0, 8, 0);
      chk("no_midframe_lock", int'(Locked), 0);
      run_until(0, 0);
      chk("locked_at_wrap", int'(Locked), 1);

      // frame 2: full INT window, DMA lines, short line 100, on/off strobes
      run_until(78, 0);
      chk("int_line78", int'(INT), 1);
      run_until(80, 0);
      chk("int_gone_line80", int'(INT), 0);
      run_until(80, 1);
      mc(0, 0, 8, 0);
      chk("dmao_rise_cycle2", int'(DMAO), 1);
      run_until(100, 0);
      for (int i = 0; i < CPL; i++) mc(0, 0, 5, 0);
      chk("overrun_set", int'(overrun), 1);
      chk("dmao_drop_at_wrap", int'(DMAO), 0);
      run_until(130, 5);
      mc(1, 0, 8, 0);
      chk("overrun_cleared", int'(overrun), 0);
      run_until(180, 4);
      chk("dmao_before_off", int'(DMAO), 1);
      mc(0, 1, 8, 0);
      chk("off_dmao", int'(DMAO), 0);
      chk("off_locked", int'(Locked), 0);
      chk("off_no_overrun", int'(overrun), 0);
      run_until(190, 0);
      mc(1, 1, 8, 0);
      run_until(0, 0);
      chk("on_off_same_clock", int'(Locked), 0);

      // frame 3: re-enable; frame 4 is displayed with a forced INT ack
      run_until(10, 3);
      mc(1, 0, 8, 0);
      run_until(0, 0);
      chk("relock", int'(Locked), 1);
      run_until(78, 2);
      chk("int_before_ack", int'(INT), 1);
      mc(0, 0, 8, 1);
      chk("int_after_ack", int'(INT), 0);
      int_ack_en = 1'b1;
      run_until(120, 3);
      mc(0, 0, 8, 0);
      chk("dmao_line120", int'(DMAO), 1);

      // asynchronous reset while a request is outstanding
      @(negedge clock);
      #1;
      Reset_ = 1'b0;
      #1;
      chk("async_reset", int'({line_count, cycle_count, DMAO, INT, EFx, Locked, overrun, byte_strobe}), 0);
      model_reset();
      int_ack_en = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      Reset_ = 1'b1;

      // frame 5: no DMA after reset until enabled; frame 6 displayed again
      run_until(200, 7);
      chk("post_reset_unlocked", int'(Locked), 0);
      mc(1, 0, 8, 0);
      int_ack_en = 1'b1;
      run_until(0, 0);
      chk("post_reset_relock", int'(Locked), 1);
      run_until(110, 0);

      @(negedge clock);
      #2;
      chk("strobe_queue_drained", strobe_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pixie_dma_scheduler.md
Name: pixie_dma_scheduler

Overview:
Timing and DMA sequencer for the CDP1861 video path of the Studio II core.
- Counts 1802 machine cycles into lines and frames.
- Generates the display interrupt, EFx frame flags and DMA-out requests to the CPU.
- Counts DMA acknowledges so the pixel shifter gets exactly one byte strobe per fetched byte.
- Sits between the cdp1802 control outputs (TPA/TPB/SC) and the cdp1861 video shifter.

Parameters:
- CYCLES_PER_LINE, 14: machine cycles per scan line.
- LINES_PER_FRAME, 262: lines per frame.
- FIRST_DMA_LINE, 80: first line with display DMA.
- DMA_LINES, 128: number of consecutive DMA lines.
- DMA_START_CYCLE, 2: cycle_count value at which DMAO is raised.
- DMA_BYTES, 8: DMA acknowledges per line.
- INT_LEAD, 2: lines of INT before FIRST_DMA_LINE.
- EF_LEAD, 4: lines of EFx before the window start and at the window end.

Ports:
- clock, in, 1: system clock.
- Reset_, in, 1: asynchronous, active-low reset.
- TPA, in, 1: one-clock pulse per machine cycle; the timebase tick.
- TPB, in, 1: one-clock pulse, late in the machine cycle.
- SC, in, 2: CPU state code (2'b10 = DMA, 2'b11 = interrupt).
- Disp_On, in, 1: one-clock display-enable strobe.
- Disp_Off, in, 1: one-clock display-disable strobe.
- DMAO, out, 1: DMA-out request to the CPU.
- INT, out, 1: interrupt request to the CPU.
- EFx, out, 1: frame flag to the CPU.
- byte_strobe, out, 1: one-clock pulse per acknowledged DMA byte.
- line_count, out, 9: current line.
- cycle_count, out, 4: current machine cycle within the line.
- Locked, out, 1: frame-enable latch (display active this frame).
- overrun, out, 1: sticky flag; a DMA window closed short of DMA_BYTES acknowledges.

Behaviour:
- Reset (Reset_ low, asynchronous): all counters, enable latches, outputs and overrun go to 0. Releasing reset mid-frame restarts at line 0, cycle 0.
- Timebase: each clock with TPA=1 increments cycle_count. CYCLES_PER_LINE-1 wraps to 0 and increments line_count. LINES_PER_FRAME-1 wraps to 0. With no TPA, counters hold.
- disp_en latch:
  - Disp_On sets it; Disp_Off clears it.
  - Both asserted in the same clock: Disp_Off wins.
  - Disp_On also clears overrun.
- Locked:
  - Loads disp_en on the TPA that wraps line_count to 0.
  - Disp_Off clears Locked immediately, on the next clock.
  - Disp_On never raises Locked mid-frame.
- INT:
  - Registered. High while Locked and line_count is in [FIRST_DMA_LINE-INT_LEAD, FIRST_DMA_LINE-1].
  - Drops early on the clock after TPB with SC=2'b11 (interrupt ack) and stays low for the rest of the frame.
  - Defaults: lines 78-79.
- EFx:
  - Registered; independent of Locked.
  - High for lines [FIRST_DMA_LINE-EF_LEAD, FIRST_DMA_LINE-1] and [FIRST_DMA_LINE+DMA_LINES-EF_LEAD, FIRST_DMA_LINE+DMA_LINES-1].
  - Defaults: 76-79 and 204-207.
- DMA state machine, states IDLE, REQ, DONE:
  - IDLE -> REQ on the TPA edge where cycle_count becomes DMA_START_CYCLE, with Locked=1 and the line inside the DMA window. DMAO rises at that same edge (registered); ack_cnt clears to 0.
  - In REQ, TPB=1 with SC=2'b10 is an ack: byte_strobe pulses that clock and ack_cnt increments.
  - On the DMA_BYTES-th ack, REQ -> DONE and DMAO is low on the next clock.
  - If cycle_count wraps to 0 while in REQ: -> IDLE, DMAO low, overrun set.
  - DONE -> IDLE at cycle wrap.
  - Disp_Off in any state: -> IDLE, DMAO low, no overrun.
  - Acks outside REQ are ignored: no byte_strobe, no count.
- Counter widths: line_count 9 bits, cycle_count 4 bits, ack_cnt 4 bits. No arithmetic overflow is possible within the parameter ranges above.

Test Plan:
- Reset, then 14*262 TPA pulses -> line_count and cycle_count return to 0/0. EFx high exactly on lines 76-79 and 204-207. INT, DMAO and Locked stay 0.
- Disp_On pulse, run to line 78 -> INT high for lines 78-79 (28 TPAs). With an SC=2'b11 ack at line 78, INT is low from the next clock.
- Locked frame, line 80: DMAO rises when cycle_count hits 2. Eight TPB+SC=2'b10 acks -> eight byte_strobe pulses; DMAO low the clock after the 8th. Same on lines 80-207; no DMAO on line 208.
- Only 5 acks on line 100 -> DMAO drops at cycle wrap and overrun=1. A following Disp_On clears overrun.
- Disp_Off with DMAO high mid-line -> DMAO and Locked 0 on the next clock, overrun stays 0. Disp_On and Disp_Off in the same clock -> disp_en 0.
- Reset_ low during REQ on line 120 -> all outputs 0 immediately. After release, counters start from 0 and no DMAO appears until the next enabled frame.
